// File: rtl/rgb_led_pwm_if.sv
`default_nettype none
// ============================================================================
// Module     : rgb_led_pwm_if
// Description: Signal bundle between the LED mapping logic and the RGB LED
//              PWM driver.
//                led_req [5:0] per-channel on request (LED1 BGR, LED0 BGR)
//                fade_en       1 = ramp duty toward target, 0 = jump
//                led_out [5:0] registered PWM outputs to the LED pins
//                busy          high while any channel duty differs from target
//              master: request side; slave: PWM driver.
// Revision   : 1.0 - initial release
// ============================================================================
interface rgb_led_pwm_if;
  logic [5:0] led_req;
  logic       fade_en;
  logic [5:0] led_out;
  logic       busy;

  modport master (
    output led_req,
    output fade_en,
    input  led_out,
    input  busy
  );

  modport slave (
    input  led_req,
    input  fade_en,
    output led_out,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/rgb_led_pwm.sv
`default_nettype none
// ============================================================================
// Module     : rgb_led_pwm
// Description: Six-channel PWM driver for the two on-board RGB LEDs. Each
//              requested-on channel is driven at a fixed brightness, with an
//              optional linear fade. Duty values only change on PWM period
//              boundaries, so the outputs never glitch.
//   Ports    : clk  - system clock
//              rst  - synchronous reset, active-high
//              bus  - rgb_led_pwm_if.slave (led_req, fade_en in;
//                     led_out, busy out)
//   Params   : CNT_W        - PWM counter width, period = 2^CNT_W clocks
//              BRIGHT       - duty for a requested-on channel
//              FADE_PERIODS - PWM periods per +/-1 duty step when fading
// Revision   : 1.0 - initial release
// ============================================================================
module rgb_led_pwm #(
  parameter int CNT_W        = 8,
  parameter int BRIGHT       = 64,
  parameter int FADE_PERIODS = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  rgb_led_pwm_if.slave bus
);

  localparam int              FC_W      = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [CNT_W-1:0] C_BRIGHT  = CNT_W'(BRIGHT);
  localparam logic [FC_W-1:0]  C_FC_LAST = FC_W'(FADE_PERIODS - 1);

  logic [CNT_W-1:0]         pwm_cnt_q;
  logic [FC_W-1:0]          fade_cnt_q;
  logic [FC_W-1:0]          fade_cnt_d;
  logic [5:0][CNT_W-1:0]    duty_q;
  logic [5:0][CNT_W-1:0]    duty_d;
  logic [5:0][CNT_W-1:0]    target;
  logic [5:0]               led_out_q;
  logic                     busy_q;
  logic                     busy_d;
  logic                     boundary;
  logic                     fade_step;

  // Last count of the period: the only cycle on which duties may change.
  assign boundary  = (pwm_cnt_q == {CNT_W{1'b1}});
  assign fade_step = bus.fade_en && (fade_cnt_q == C_FC_LAST);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_target
      assign target[gi] = bus.led_req[gi] ? C_BRIGHT : '0;
    end
  endgenerate

  // Next duty per channel. Stepping only when strictly below/above target
  // makes the ramp saturate at target, so it can never wrap at 0 or max.
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < 6; i++) begin
      duty_d[i] = duty_q[i];
      if (!bus.fade_en) begin
        duty_d[i] = target[i];
      end else if (fade_step) begin
        if (duty_q[i] < target[i]) begin
          duty_d[i] = duty_q[i] + 1'b1;
        end else if (duty_q[i] > target[i]) begin
          duty_d[i] = duty_q[i] - 1'b1;
        end
      end
      if (duty_d[i] != target[i]) begin
        busy_d = 1'b1;
      end
    end
  end

  always_comb begin
    fade_cnt_d = '0;
    if (bus.fade_en && !fade_step) begin
      fade_cnt_d = fade_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      duty_q     <= '0;
      led_out_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      // Compare uses the pre-increment count, so outputs lag the counter by
      // one cycle and every channel rises together at count 0.
      for (int i = 0; i < 6; i++) begin
        led_out_q[i] <= (pwm_cnt_q < duty_q[i]);
      end
      // busy reflects the post-update duties and is refreshed with them.
      if (boundary) begin
        duty_q     <= duty_d;
        fade_cnt_q <= fade_cnt_d;
        busy_q     <= busy_d;
      end
    end
  end

  assign bus.led_out = led_out_q;
  assign bus.busy    = busy_q;

endmodule
`default_nettype wire
